// File: rtl/tick_period_checker.sv
// Receive-side checker for the generator's periodic tick: measures enable-qualified
// tick spacing, reports each period, tracks lock and raises a sticky error.
module tick_period_checker #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned EXP_PERIOD = 4,
    parameter int unsigned TOL        = 0,
    parameter int unsigned LOCK_COUNT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             tick,
    input  logic             clr_err,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             lock,
    output logic             err
);

    localparam int unsigned GoodW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);

    localparam logic [WIDTH-1:0] Exp     = WIDTH'(EXP_PERIOD);
    localparam logic [WIDTH-1:0] Tol     = WIDTH'(TOL);
    localparam logic [WIDTH-1:0] Limit   = WIDTH'(EXP_PERIOD + TOL);
    localparam logic [WIDTH-1:0] CntMax  = '1;
    localparam logic [GoodW-1:0] LockMax = GoodW'(LOCK_COUNT);

    typedef enum logic [0:0] {StIdle, StMeas} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [GoodW-1:0] good_cnt_q, good_cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             period_valid_q, period_valid_d;
    logic             lock_q, lock_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] measured;
    logic [WIDTH-1:0] diff;
    logic             new_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            good_cnt_q     <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            lock_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            good_cnt_q     <= good_cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            lock_q         <= lock_d;
            err_q          <= err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        good_cnt_d     = good_cnt_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        lock_d         = lock_q;
        new_err        = 1'b0;

        // The ticking cycle itself counts when enabled; saturate rather than wrap.
        measured = (cnt_q == CntMax) ? cnt_q : cnt_q + WIDTH'(enable);
        diff     = (measured >= Exp) ? measured - Exp : Exp - measured;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (tick) begin
                    state_d = StMeas;
                end
            end
            StMeas: begin
                if (tick) begin
                    period_d       = measured;
                    period_valid_d = 1'b1;
                    cnt_d          = '0;
                    if (diff <= Tol) begin
                        if (good_cnt_q != LockMax) begin
                            good_cnt_d = good_cnt_q + GoodW'(1);
                        end
                        if (good_cnt_d == LockMax) begin
                            lock_d = 1'b1;
                        end
                    end else begin
                        good_cnt_d = '0;
                        lock_d     = 1'b0;
                        new_err    = 1'b1;
                    end
                end else if (enable) begin
                    if (cnt_q == Limit) begin
                        // Tick overdue: drop lock and resynchronise on the next tick.
                        new_err    = 1'b1;
                        lock_d     = 1'b0;
                        good_cnt_d = '0;
                        state_d    = StIdle;
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        err_d = new_err | (err_q & ~clr_err);
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign lock         = lock_q;
    assign err          = err_q;

endmodule

// File: tb/tb_tick_period_checker.sv
// Directed bench for tick_period_checker: a period/lock/error model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_tick_period_checker;

    localparam int unsigned WIDTH      = 8;
    localparam int unsigned EXP_PERIOD = 4;
    localparam int unsigned TOL        = 0;
    localparam int unsigned LOCK_COUNT = 3;
    localparam int unsigned MAXV       = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             tick;
    logic             clr_err;
    logic [WIDTH-1:0] period;
    logic             period_valid;
    logic             lock;
    logic             err;

    int n_cmp  = 0;
    int n_fail = 0;

    tick_period_checker #(
        .WIDTH     (WIDTH),
        .EXP_PERIOD(EXP_PERIOD),
        .TOL       (TOL),
        .LOCK_COUNT(LOCK_COUNT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .tick        (tick),
        .clr_err     (clr_err),
        .period      (period),
        .period_valid(period_valid),
        .lock        (lock),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: enabled cycles since the last tick, and the history of period verdicts.
    bit          m_sync;
    int unsigned m_since;
    bit          ok_hist[$];
    int unsigned e_period;
    bit          e_pv, e_lock, e_err;

    always @(posedge clk or negedge rst) begin
        bit          new_err;
        int unsigned meas;
        int unsigned dev;
        if (!rst) begin
            m_sync   = 0;
            m_since  = 0;
            ok_hist.delete();
            e_period = 0;
            e_pv     = 0;
            e_lock   = 0;
            e_err    = 0;
        end else begin
            new_err = 0;
            e_pv    = 0;
            if (tick) begin
                if (m_sync) begin
                    meas = m_since + (enable ? 1 : 0);
                    if (meas > MAXV) meas = MAXV;
                    e_period = meas;
                    e_pv     = 1;
                    dev      = (meas >= EXP_PERIOD) ? meas - EXP_PERIOD : EXP_PERIOD - meas;
                    ok_hist.push_back(dev <= TOL);
                    if (dev > TOL) new_err = 1;
                    if (ok_hist.size() > LOCK_COUNT) void'(ok_hist.pop_front());
                end
                m_sync  = 1;
                m_since = 0;
            end else if (m_sync && enable) begin
                m_since++;
                if (m_since > EXP_PERIOD + TOL) begin
                    new_err = 1;
                    m_sync  = 0;
                    m_since = 0;
                    ok_hist.delete();
                end
            end
            e_lock = (ok_hist.size() == LOCK_COUNT);
            foreach (ok_hist[i]) if (!ok_hist[i]) e_lock = 0;
            e_err = new_err | (e_err & !clr_err);
        end
    end

    always @(negedge clk) begin
        check("period", 32'(period), e_period);
        check("period_valid", 32'(period_valid), 32'(e_pv));
        check("lock", 32'(lock), 32'(e_lock));
        check("err", 32'(err), 32'(e_err));
    end

    // Drive one cycle's inputs, then step to just after the edge that samples them.
    task automatic cyc(input bit en, input bit tk, input bit clr);
        enable  = en;
        tick    = tk;
        clr_err = clr;
        @(posedge clk);
        #2;
    endtask

    task automatic tick_gap(input int gap);
        repeat (gap) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; enable = 1'b0; tick = 1'b0; clr_err = 1'b0;
        repeat (4) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check("rst_period", 32'(period), 0);
        check("rst_pv", 32'(period_valid), 0);
        check("rst_lock", 32'(lock), 0);
        check("rst_err", 32'(err), 0);
        rst = 1'b1;
        repeat (2) cyc(1'b0, 1'b0, 1'b0);

        // Nominal: first tick only synchronises, lock on the third good period.
        cyc(1'b1, 1'b1, 1'b0);
        check("sync_no_strobe", 32'(period_valid), 0);
        tick_gap(3);
        check("nom_pv", 32'(period_valid), 1);
        check("nom_period", 32'(period), 4);
        check("nom_lock_early", 32'(lock), 0);
        tick_gap(3);
        check("nom_lock_2", 32'(lock), 0);
        tick_gap(3);
        check("lock_rise", 32'(lock), 1);
        tick_gap(3);
        check("nom_err", 32'(err), 0);

        // Enable gaps: ticks 6 clocks apart with 2 disabled cycles still measure 4.
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        check("gap_period", 32'(period), 4);
        check("gap_lock", 32'(lock), 1);

        // Short period, clear, relock.
        tick_gap(2);
        check("short_period", 32'(period), 3);
        check("short_lock", 32'(lock), 0);
        check("short_err", 32'(err), 1);
        cyc(1'b1, 1'b0, 1'b1);
        check("clr_err", 32'(err), 0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        check("relock_period", 32'(period), 4);
        tick_gap(3);
        tick_gap(3);
        check("relock", 32'(lock), 1);

        // Missing tick: timeout after the 5th enabled cycle, then resync.
        repeat (4) cyc(1'b1, 1'b0, 1'b0);
        check("pre_timeout_err", 32'(err), 0);
        cyc(1'b1, 1'b0, 1'b0);
        check("timeout_err", 32'(err), 1);
        check("timeout_lock", 32'(lock), 0);
        check("timeout_pv", 32'(period_valid), 0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        check("resync_no_strobe", 32'(period_valid), 0);
        tick_gap(3);
        check("resync_period", 32'(period), 4);
        check("resync_err_sticky", 32'(err), 1);

        // Collision of clr_err with a bad period, then back-to-back and disabled ticks.
        cyc(1'b1, 1'b0, 1'b1);
        check("clr_err2", 32'(err), 0);
        cyc(1'b1, 1'b1, 1'b1);
        check("collision_err", 32'(err), 1);
        check("collision_period", 32'(period), 2);
        cyc(1'b1, 1'b1, 1'b0);
        check("b2b_period", 32'(period), 1);
        check("b2b_pv", 32'(period_valid), 1);
        cyc(1'b0, 1'b1, 1'b0);
        check("dis_tick_period", 32'(period), 0);
        check("dis_tick_pv", 32'(period_valid), 1);

        // Lock again, then asynchronous reset mid-measurement.
        tick_gap(3);
        tick_gap(3);
        tick_gap(3);
        check("lock_before_rst", 32'(lock), 1);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        #1 rst = 1'b0;
        #1;
        check("async_period", 32'(period), 0);
        check("async_lock", 32'(lock), 0);
        check("async_err", 32'(err), 0);
        check("async_pv", 32'(period_valid), 0);
        cyc(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        cyc(1'b1, 1'b1, 1'b0);
        check("post_rst_sync", 32'(period_valid), 0);
        tick_gap(3);
        check("post_rst_period", 32'(period), 4);
        check("post_rst_lock", 32'(lock), 0);
        cyc(1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/tick_period_checker.md
# tick_period_checker

Receive-side checker for the periodic single-cycle tick produced by the team's `Counter` generator. It measures how many enable-qualified cycles separate consecutive ticks and reports each measured period. It asserts `lock` after a run of in-tolerance periods and raises a sticky `err` on short, long or missing ticks. It sits downstream of the generator's `out` pin and shares the generator's `clk` and `enable`.

## Interface
- `WIDTH`, default 8: width of the period counter and of `period`.
- `EXP_PERIOD`, default 4: expected period, in enabled cycles. 4 matches a generator with MIN_VALUE=10 and MAX_VALUE=13.
- `TOL`, default 0: allowed deviation, |measured − EXP_PERIOD| ≤ TOL. Requires EXP_PERIOD+TOL < 2^WIDTH−1.
- `LOCK_COUNT`, default 3: number of consecutive good periods required to assert `lock`.

Ports:
- `clk`  in  1  rising-edge clock, the only clock.
- `rst`  in  1  asynchronous, active-low reset.
- `enable`  in  1  count qualifier, the same signal that drives the generator.
- `tick`  in  1  single-cycle pulse from the generator.
- `clr_err`  in  1  synchronous clear of `err`.
- `period`  out  WIDTH  last measured period, registered.
- `period_valid`  out  1  one-cycle strobe: `period` updated.
- `lock`  out  1  high while the last LOCK_COUNT periods were all good.
- `err`  out  1  sticky error flag.

## Operation
- Internal state: `cnt` (WIDTH bits), `good_cnt` (0..LOCK_COUNT), and FSM state IDLE or MEAS.
- IDLE:
  - `cnt` is held at 0.
  - On `tick`=1, go to MEAS with `cnt`=0. No `period_valid` is produced, because the first tick only synchronises.
- MEAS with `tick`=0:
  - If `enable`=1, `cnt` increments.
  - If `enable`=1 and `cnt`==EXP_PERIOD+TOL, this is a timeout:
    - `err`←1, `lock`←0, `good_cnt`←0.
    - FSM goes to IDLE and `cnt`←0.
    - No `period_valid` is produced.
- MEAS with `tick`=1:
  - measured = `cnt` + `enable`, in WIDTH bits, saturating at 2^WIDTH−1.
  - Outputs: `period`←measured, `period_valid`←1, `cnt`←0; the FSM stays in MEAS.
  - Good period (|measured − EXP_PERIOD| ≤ TOL): `good_cnt` increments, saturating at LOCK_COUNT; `lock`←1 once `good_cnt` reaches LOCK_COUNT.
  - Bad period: `good_cnt`←0, `lock`←0, `err`←1.
- Arithmetic: the comparison is unsigned. Compute |a−b| as (a≥b ? a−b : b−a) to avoid wrap-around.
- `err` priority: a new error in the same cycle as `clr_err`=1 leaves `err`=1. `clr_err` on its own clears `err` at the next edge. `clr_err` never affects `lock` or the FSM.
- Reset (`rst`=0, asynchronous, valid at any point including mid-measurement):
  - FSM returns to IDLE; `cnt`=0, `good_cnt`=0.
  - `period`=0, `period_valid`=0, `lock`=0, `err`=0.
  - Operation resumes on the first clock edge with `rst`=1.
- `enable`=0 freezes `cnt` but not tick detection. A tick with `enable`=0 is measured as `cnt` alone.

## Timing
- All outputs are registered, and all updates happen on the rising edge of `clk`, except reset, which is asynchronous.
- `period`, `period_valid`, and the `lock`/`err` changes caused by a tick are visible one cycle after the cycle in which `tick` is sampled high.
- `lock` rises on the same edge as the LOCK_COUNT-th consecutive good `period_valid`. It falls on the edge of the first bad period or timeout.
- A timeout `err` is visible one cycle after the enabled cycle in which `cnt`==EXP_PERIOD+TOL without a tick.
- Back-to-back ticks (measured=1) are legal and are measured normally.

## Test plan
- Reset: hold `rst`=0 with random inputs → `period`=0, `period_valid`=0, `lock`=0, `err`=0. Asserting `rst` mid-measurement zeroes all outputs immediately, without waiting for a clock edge.
- Nominal: `enable`=1, `tick` every 4 clocks, 5 ticks → no strobe on tick 1; strobes with `period`=4 on ticks 2–5; `lock`=1 from the 4th tick's strobe; `err` stays 0.
- Enable gaps: after lock, drop `enable` for 2 cycles between ticks that are 6 clocks apart → `period`=4, `lock` stays 1.
- Short period: after lock, a tick arrives 3 enabled cycles after the previous one → `period`=3, `lock`=0, `err`=1. Pulse `clr_err` → `err`=0 on the next edge. Three more 4-cycle periods → `lock`=1 again.
- Missing tick: after lock, hold `tick`=0 with `enable`=1 → `err`=1 and `lock`=0 one cycle after the 5th enabled cycle following the last tick; FSM returns to IDLE. The next tick produces no strobe, and the tick after it reports `period`=4.
- Collision: a bad period coincides with `clr_err`=1 → `err` remains 1.
